// File: rtl/riscv_pkg.sv
// Shared core definitions: ALU opcodes, load/store size codes, LSU FSM states
// and the legality/alignment rule used by the load-store unit.
package riscv_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_e;

   // Codes 3, 6 and 7 are deliberately left out: they are illegal sizes.
   typedef enum logic [2:0] {
      LDST_B  = 3'd0,
      LDST_H  = 3'd1,
      LDST_W  = 3'd2,
      LDST_BU = 3'd4,
      LDST_HU = 3'd5
   } ldst_e;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_BUSY = 2'd1,
      LSU_RESP = 2'd2
   } lsu_state_e;

   // True when the size code is legal and the address is naturally aligned.
   function automatic logic ldst_ok(input ldst_e size, input logic [1:0] addr_lo);
      logic ok;
      ok = 1'b0;
      case (size)
         LDST_B, LDST_BU: ok = 1'b1;
         LDST_H, LDST_HU: ok = ~addr_lo[0];
         LDST_W:          ok = (addr_lo == 2'b00);
         default:         ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering for the LSU: byte enables and lane-replicated store data
// towards memory, lane extraction plus sign/zero extension for loads.
module riscv_lsu_align
   import riscv_pkg::*;
(
   input  ldst_e       size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wd,
   input  logic [31:0] mem_rd,
   output logic [3:0]  be,
   output logic [31:0] wd_rep,
   output logic [31:0] rd_ext
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Pick the byte and halfword lanes addressed by the low address bits.
   always_comb begin
      lane_b = mem_rd[7:0];
      case (addr_lo)
         2'd0: lane_b = mem_rd[7:0];
         2'd1: lane_b = mem_rd[15:8];
         2'd2: lane_b = mem_rd[23:16];
         2'd3: lane_b = mem_rd[31:24];
         default: lane_b = mem_rd[7:0];
      endcase
      lane_h = addr_lo[1] ? mem_rd[31:16] : mem_rd[15:0];
   end

   // Steer enables, replicate store data and extend the load lane by size.
   always_comb begin
      be     = 4'b0000;
      wd_rep = wd;
      rd_ext = 32'd0;
      case (size)
         LDST_B: begin
            be     = 4'b0001 << addr_lo;
            wd_rep = {4{wd[7:0]}};
            rd_ext = {{24{lane_b[7]}}, lane_b};
         end
         LDST_BU: begin
            be     = 4'b0001 << addr_lo;
            wd_rep = {4{wd[7:0]}};
            rd_ext = {24'd0, lane_b};
         end
         LDST_H: begin
            be     = addr_lo[1] ? 4'b1100 : 4'b0011;
            wd_rep = {2{wd[15:0]}};
            rd_ext = {{16{lane_h[15]}}, lane_h};
         end
         LDST_HU: begin
            be     = addr_lo[1] ? 4'b1100 : 4'b0011;
            wd_rep = {2{wd[15:0]}};
            rd_ext = {16'd0, lane_h};
         end
         LDST_W: begin
            be     = 4'b1111;
            wd_rep = wd;
            rd_ext = mem_rd;
         end
         default: begin
            be     = 4'b0000;
            wd_rep = wd;
            rd_ext = 32'd0;
         end
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit: accepts one access from the core, runs it on the data
// memory port with a timeout, and returns the extended load result.
module riscv_lsu
   import riscv_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_req_o,
   output logic        lsu_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i,
   input  logic        mem_ready_i
);

   localparam int CW = $clog2(TIMEOUT + 1);
   // The timeout fires in the BUSY cycle whose count is one short of TIMEOUT,
   // so exactly TIMEOUT cycles of mem_req_o are seen before giving up.
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   lsu_state_e  state_q, state_d;
   logic        we_q;
   ldst_e       size_q;
   logic [31:0] addr_q;
   logic [31:0] wd_q;
   logic [CW-1:0] cnt_q;
   logic [31:0] rd_q;
   logic        err_q;

   logic        access_ok;
   logic        start;
   logic        done_ok;
   logic        timeout;
   logic        req_err;
   logic [3:0]  be_a;
   logic [31:0] rd_ext;

   assign access_ok  = ldst_ok(ldst_e'(core_size_i), core_addr_i[1:0]);
   assign core_rd_o  = rd_q;
   assign lsu_err_o  = err_q;
   assign mem_addr_o = {addr_q[31:2], 2'b00};

   riscv_lsu_align u_align (
      .size    (size_q),
      .addr_lo (addr_q[1:0]),
      .wd      (wd_q),
      .mem_rd  (mem_rd_i),
      .be      (be_a),
      .wd_rep  (mem_wd_o),
      .rd_ext  (rd_ext)
   );

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) state_q <= LSU_IDLE;
      else         state_q <= state_d;
   end

   // Next state, stall and memory-port drive for the current state.
   always_comb begin
      state_d          = state_q;
      core_stall_req_o = 1'b0;
      mem_req_o        = 1'b0;
      mem_we_o         = 1'b0;
      mem_be_o         = 4'b0000;
      start            = 1'b0;
      done_ok          = 1'b0;
      timeout          = 1'b0;
      req_err          = 1'b0;
      case (state_q)
         LSU_IDLE: begin
            if (core_req_i) begin
               if (access_ok) begin
                  core_stall_req_o = 1'b1;
                  start            = 1'b1;
                  state_d          = LSU_BUSY;
               end else begin
                  req_err = 1'b1;
               end
            end
         end
         LSU_BUSY: begin
            core_stall_req_o = 1'b1;
            mem_req_o        = 1'b1;
            mem_we_o         = we_q;
            mem_be_o         = be_a;
            if (mem_ready_i) begin
               done_ok = 1'b1;
               state_d = LSU_RESP;
            end else if (cnt_q == CNT_LAST) begin
               timeout = 1'b1;
               state_d = LSU_RESP;
            end
         end
         LSU_RESP: begin
            state_d = LSU_IDLE;
         end
         default: begin
            state_d = LSU_IDLE;
         end
      endcase
   end

   // Request latches, timeout counter, load result and error pulse.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         we_q   <= 1'b0;
         size_q <= LDST_B;
         addr_q <= 32'd0;
         wd_q   <= 32'd0;
         cnt_q  <= '0;
         rd_q   <= 32'd0;
         err_q  <= 1'b0;
      end else begin
         err_q <= req_err | timeout;
         if (start) begin
            we_q   <= core_we_i;
            size_q <= ldst_e'(core_size_i);
            addr_q <= core_addr_i;
            wd_q   <= core_wd_i;
            cnt_q  <= '0;
         end else if (state_q == LSU_BUSY && !mem_ready_i) begin
            cnt_q <= cnt_q + CW'(1);
         end
         if (done_ok && !we_q) rd_q <= rd_ext;
         else if (timeout && !we_q) rd_q <= 32'd0;
      end
   end

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed scenarios plus randomized
// accesses compared against a byte-arithmetic reference model.
module tb_riscv_lsu;

   localparam int TO = 4;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        core_req_i;
   logic        core_we_i;
   logic [2:0]  core_size_i;
   logic [31:0] core_addr_i;
   logic [31:0] core_wd_i;
   logic [31:0] core_rd_o;
   logic        core_stall_req_o;
   logic        lsu_err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wd_o;
   logic [31:0] mem_rd_i;
   logic        mem_ready_i;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_rd;

   riscv_lsu #(.TIMEOUT(TO)) dut (
      .clk_i            (clk_i),
      .rstn_i           (rstn_i),
      .core_req_i       (core_req_i),
      .core_we_i        (core_we_i),
      .core_size_i      (core_size_i),
      .core_addr_i      (core_addr_i),
      .core_wd_i        (core_wd_i),
      .core_rd_o        (core_rd_o),
      .core_stall_req_o (core_stall_req_o),
      .lsu_err_o        (lsu_err_o),
      .mem_req_o        (mem_req_o),
      .mem_we_o         (mem_we_o),
      .mem_be_o         (mem_be_o),
      .mem_addr_o       (mem_addr_o),
      .mem_wd_o         (mem_wd_o),
      .mem_rd_i         (mem_rd_i),
      .mem_ready_i      (mem_ready_i)
   );

   // Free-running clock, 10 ns period.
   always #5 clk_i = ~clk_i;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no end of sequence, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int unsigned nbytes(input logic [2:0] s);
      case (s)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         3'd2:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic logic is_legal(input logic [2:0] s, input logic [31:0] a);
      int unsigned n;
      n = nbytes(s);
      return (n != 0) && ((a % n) == 0);
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] s, input logic [31:0] a);
      logic [31:0] m;
      m = (32'd1 << (8'(nbytes(s)))) - 32'd1;
      m = m << (a % 4);
      return m[3:0];
   endfunction

   function automatic logic [31:0] exp_wd(input logic [2:0] s, input logic [31:0] wd);
      case (nbytes(s))
         1:       return (wd & 32'h0000_00FF) * 32'h0101_0101;
         2:       return (wd & 32'h0000_FFFF) * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] s, input logic [31:0] a,
                                            input logic [31:0] rdata);
      int unsigned n;
      logic [31:0] v;
      logic [31:0] span;
      n = nbytes(s);
      v = rdata >> (8 * (a % 4));
      if (n < 4) begin
         span = 32'd1 << (8 * n);
         v = v % span;
         if ((s == 3'd0 || s == 3'd1) && v >= (span / 2)) v = v - span;
      end
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic we, input logic [2:0] size,
                                input logic [31:0] addr, input logic [31:0] wd);
      core_req_i  = req;
      core_we_i   = we;
      core_size_i = size;
      core_addr_i = addr;
      core_wd_i   = wd;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // One core access; delay = BUSY cycles before ready, >= TO means no ready.
   task automatic doAccess(input string tag, input logic we, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdata, input int delay);
      logic legal;
      logic timed_out;
      legal     = is_legal(size, addr);
      timed_out = (delay >= TO);
      applyStimulus(1'b1, we, size, addr, wd);
      mem_ready_i = 1'b0;
      #1;
      checkOutput({tag, ".stall_idle"}, core_stall_req_o, legal);
      checkOutput({tag, ".req_idle"}, mem_req_o, 0);
      if (!legal) begin
         tick();
         applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
         #1;
         checkOutput({tag, ".err"}, lsu_err_o, 1);
         checkOutput({tag, ".req_after_err"}, mem_req_o, 0);
         checkOutput({tag, ".stall_after_err"}, core_stall_req_o, 0);
         checkOutput({tag, ".rd_kept"}, core_rd_o, model_rd);
         tick();
         checkOutput({tag, ".err_clear"}, lsu_err_o, 0);
         return;
      end
      tick();
      for (int k = 0; k < TO; k++) begin
         mem_ready_i = (k == delay);
         mem_rd_i    = (k == delay) ? rdata : $urandom;
         #1;
         checkOutput({tag, ".busy_req"}, mem_req_o, 1);
         checkOutput({tag, ".busy_we"}, mem_we_o, we);
         checkOutput({tag, ".busy_be"}, mem_be_o, exp_be(size, addr));
         checkOutput({tag, ".busy_addr"}, mem_addr_o, addr & 32'hFFFF_FFFC);
         checkOutput({tag, ".busy_stall"}, core_stall_req_o, 1);
         if (we) checkOutput({tag, ".busy_wd"}, mem_wd_o, exp_wd(size, wd));
         tick();
         if (k == delay) break;
      end
      mem_ready_i = 1'b0;
      if (!we) model_rd = timed_out ? 32'd0 : exp_load(size, addr, rdata);
      #1;
      checkOutput({tag, ".resp_stall"}, core_stall_req_o, 0);
      checkOutput({tag, ".resp_req"}, mem_req_o, 0);
      checkOutput({tag, ".resp_be"}, mem_be_o, 0);
      checkOutput({tag, ".resp_err"}, lsu_err_o, timed_out);
      checkOutput({tag, ".resp_rd"}, core_rd_o, model_rd);
      tick();
      applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      #1;
      checkOutput({tag, ".idle_err"}, lsu_err_o, 0);
      checkOutput({tag, ".idle_req"}, mem_req_o, 0);
      checkOutput({tag, ".idle_stall"}, core_stall_req_o, 0);
   endtask

   // Directed scenarios, a randomized run, then reset in the middle of BUSY.
   initial begin
      logic [2:0]  store_sizes [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
      logic        r_we;
      logic [2:0]  r_size;
      logic [31:0] r_addr;
      logic [31:0] r_wd;
      logic [31:0] r_rd;
      int          r_delay;

      rstn_i      = 1'b0;
      mem_ready_i = 1'b0;
      mem_rd_i    = 32'd0;
      model_rd    = 32'd0;
      applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      tick();
      tick();
      checkOutput("reset.req", mem_req_o, 0);
      checkOutput("reset.we", mem_we_o, 0);
      checkOutput("reset.be", mem_be_o, 0);
      checkOutput("reset.rd", core_rd_o, 0);
      checkOutput("reset.err", lsu_err_o, 0);
      checkOutput("reset.stall", core_stall_req_o, 0);
      rstn_i = 1'b1;
      tick();

      $display("[TB] directed accesses");
      doAccess("lb_103", 1'b0, 3'd0, 32'h0000_0103, 32'd0, 32'h8000_0000, 0);
      checkOutput("lb_103.value", model_rd, 32'hFFFF_FF80);
      doAccess("sh_202", 1'b1, 3'd1, 32'h0000_0202, 32'h0000_BEEF, 32'd0, 1);
      doAccess("lw_101", 1'b0, 3'd2, 32'h0000_0101, 32'd0, 32'd0, 0);
      doAccess("size3", 1'b0, 3'd3, 32'h0000_0100, 32'd0, 32'd0, 0);
      doAccess("lhu_timeout", 1'b0, 3'd5, 32'h0000_0000, 32'd0, 32'd0, TO);

      $display("[TB] randomized accesses");
      for (int i = 0; i < 60; i++) begin
         r_we    = 1'($urandom_range(0, 1));
         r_size  = r_we ? store_sizes[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
         r_addr  = $urandom;
         if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~((32'd1 << (r_size[1:0] == 2'd2 ? 2 : r_size[1:0])) - 32'd1);
         r_wd    = $urandom;
         r_rd    = $urandom;
         r_delay = $urandom_range(0, 5);
         doAccess("rand", r_we, r_size, r_addr, r_wd, r_rd, r_delay);
      end

      $display("[TB] reset during busy");
      doAccess("lw_prime", 1'b0, 3'd2, 32'h0000_0040, 32'd0, 32'h1234_5678, 0);
      applyStimulus(1'b1, 1'b0, 3'd2, 32'h0000_0400, 32'd0);
      mem_ready_i = 1'b0;
      tick();
      #1;
      checkOutput("rst_busy.req1", mem_req_o, 1);
      tick();
      rstn_i = 1'b0;
      #1;
      checkOutput("rst_busy.req2", mem_req_o, 1);
      tick();
      rstn_i = 1'b1;
      applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      model_rd = 32'd0;
      #1;
      checkOutput("rst_busy.req_after", mem_req_o, 0);
      checkOutput("rst_busy.stall_after", core_stall_req_o, 0);
      checkOutput("rst_busy.rd_after", core_rd_o, model_rd);
      checkOutput("rst_busy.err_after", lsu_err_o, 0);
      tick();
      checkOutput("rst_busy.err_next", lsu_err_o, 0);
      checkOutput("rst_busy.req_next", mem_req_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
